rgb565_grayscale_stream: RTL and testbench

//  Streaming RGB565 -> 8-bit grayscale converter; parametrised successor of the combinational converter.

---
 rtl/grayscale_pkg.sv | 24 ++
 rtl/gray_packer.sv | 77 +++++++
 rtl/rgb565_grayscale_stream.sv | 127 ++++++++++++
 tb/tb_rgb565_grayscale_stream.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grayscale_pkg.sv
// rtl/grayscale_pkg.sv - shared types, default weights and channel expansion for the grayscale stream.
package grayscale_pkg;

  localparam int GRAY_W         = 8;
  localparam int COEF_R_DEFAULT = 54;
  localparam int COEF_G_DEFAULT = 183;
  localparam int COEF_B_DEFAULT = 19;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Bit replication maps full-scale 5/6-bit codes onto 255 exactly.
  function automatic logic [7:0] exp5to8(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  function automatic logic [7:0] exp6to8(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

endpackage

// File: rtl/gray_packer.sv
// rtl/gray_packer.sv - packs PIX_IN gray bytes per beat into OUT_PIX-byte words with byte enables.
module gray_packer
  import grayscale_pkg::*;
#(
  parameter int PIX_IN  = 2,
  parameter int OUT_PIX = 4
) (
  input  logic                      clock,
  input  logic                      nReset,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [GRAY_W*PIX_IN-1:0]  pix_data,
  input  logic                      pix_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [GRAY_W*OUT_PIX-1:0] out_data,
  output logic [OUT_PIX-1:0]        out_byte_en,
  output logic                      out_last
);

  localparam int PTR_W = (OUT_PIX > 1) ? $clog2(OUT_PIX) : 1;
  localparam logic [PTR_W:0] STEP    = PIX_IN[PTR_W:0];
  localparam logic [PTR_W:0] PTR_END = OUT_PIX[PTR_W:0];

  logic [PTR_W:0]              ptr, ptr_next;
  logic [GRAY_W*OUT_PIX-1:0]   acc_data, ext_data, new_data;
  logic [OUT_PIX-1:0]          acc_en, ext_en, new_en;
  logic                        complete, out_free, take;

  always_comb begin
    ext_data = '0;
    ext_data[GRAY_W*PIX_IN-1:0] = pix_data;
    ext_en = '0;
    ext_en[PIX_IN-1:0] = '1;
    new_data = acc_data | (ext_data << {ptr, 3'b000});
    new_en   = acc_en | (ext_en << ptr);
    ptr_next = ptr + STEP;
  end

  // Only a beat that closes a word needs the output register to be free.
  assign complete  = pix_last || (ptr_next == PTR_END);
  assign out_free  = !out_valid || out_ready;
  assign pix_ready = !complete || out_free;
  assign take      = pix_valid && pix_ready;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      ptr         <= '0;
      acc_data    <= '0;
      acc_en      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_byte_en <= '0;
      out_last    <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (take) begin
        if (complete) begin
          out_valid   <= 1'b1;
          out_data    <= new_data;
          out_byte_en <= new_en;
          out_last    <= pix_last;
          acc_data    <= '0;
          acc_en      <= '0;
          ptr         <= '0;
        end else begin
          acc_data <= new_data;
          acc_en   <= new_en;
          ptr      <= ptr_next;
        end
      end
    end
  end

endmodule

// File: rtl/rgb565_grayscale_stream.sv
// rtl/rgb565_grayscale_stream.sv - RGB565 to 8-bit grayscale stream: weight stage, sum stage, packer.
// Define GRAYSCALE_ROUND_EN for round-to-nearest; default build truncates.
module rgb565_grayscale_stream
  import grayscale_pkg::*;
#(
  parameter int PIX_IN  = 2,
  parameter int OUT_PIX = 4,
  parameter int COEF_R  = COEF_R_DEFAULT,
  parameter int COEF_G  = COEF_G_DEFAULT,
  parameter int COEF_B  = COEF_B_DEFAULT
) (
  input  logic                      clock,
  input  logic                      nReset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [16*PIX_IN-1:0]      in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [GRAY_W*OUT_PIX-1:0] out_data,
  output logic [OUT_PIX-1:0]        out_byte_en,
  output logic                      out_last
);

  if ((COEF_R + COEF_G + COEF_B) != 256) begin : g_coef_check
    $error("rgb565_grayscale_stream: COEF_R+COEF_G+COEF_B must equal 256");
  end
  if ((OUT_PIX % PIX_IN) != 0) begin : g_pack_check
    $error("rgb565_grayscale_stream: OUT_PIX must be a multiple of PIX_IN");
  end

  localparam logic [7:0] CR = COEF_R[7:0];
  localparam logic [7:0] CG = COEF_G[7:0];
  localparam logic [7:0] CB = COEF_B[7:0];

  logic [PIX_IN-1:0][15:0]       pr_n, pg_n, pb_n, s1_pr, s1_pg, s1_pb;
  logic [PIX_IN-1:0][GRAY_W-1:0] gray_n, s2_gray;
  logic                          s1_valid, s1_last, s1_adv;
  logic                          s2_valid, s2_last, s2_adv, s2_load;
  logic                          pk_ready;
  rgb565_t                       px;
  logic [17:0]                   sum;
  logic [9:0]                    q;

  always_comb begin
    px   = '0;
    pr_n = '0;
    pg_n = '0;
    pb_n = '0;
    for (int k = 0; k < PIX_IN; k++) begin
      px      = in_data[16*k +: 16];
      pr_n[k] = {8'd0, CR} * {8'd0, exp5to8(px.r)};
      pg_n[k] = {8'd0, CG} * {8'd0, exp6to8(px.g)};
      pb_n[k] = {8'd0, CB} * {8'd0, exp5to8(px.b)};
    end
  end

  always_comb begin
    sum    = '0;
    q      = '0;
    gray_n = '0;
    for (int k = 0; k < PIX_IN; k++) begin
      sum = {2'b00, s1_pr[k]} + {2'b00, s1_pg[k]} + {2'b00, s1_pb[k]};
`ifdef GRAYSCALE_ROUND_EN
      sum = sum + 18'd128;
`endif
      q         = sum[17:8];
      gray_n[k] = (q > 10'd255) ? 8'hFF : q[7:0];
    end
  end

  // Ready depends only on pipeline occupancy, never on in_valid.
  assign s2_adv   = s2_valid && pk_ready;
  assign s2_load  = !s2_valid || s2_adv;
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = nReset && (!s1_valid || s1_adv);

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_pr    <= '0;
      s1_pg    <= '0;
      s1_pb    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last <= in_last;
        s1_pr   <= pr_n;
        s1_pg   <= pg_n;
        s1_pb   <= pb_n;
      end
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_gray  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last <= s1_last;
        s2_gray <= gray_n;
      end
    end
  end

  gray_packer #(
    .PIX_IN  (PIX_IN),
    .OUT_PIX (OUT_PIX)
  ) u_packer (
    .clock       (clock),
    .nReset      (nReset),
    .pix_valid   (s2_valid),
    .pix_ready   (pk_ready),
    .pix_data    (s2_gray),
    .pix_last    (s2_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_byte_en (out_byte_en),
    .out_last    (out_last)
  );

endmodule

// File: tb/tb_rgb565_grayscale_stream.sv
// tb/tb_rgb565_grayscale_stream.sv - scoreboard bench for the grayscale stream, PIX_IN=2 / OUT_PIX=4.
module tb_rgb565_grayscale_stream;

  logic        clock, nReset;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [3:0]  out_byte_en;

  int checks = 0;
  int passes = 0;

  logic [31:0] stim_data[$];
  logic        stim_last[$];
  logic [31:0] exp_data[$];
  logic [3:0]  exp_en[$];
  logic        exp_last[$];
  logic [31:0] obs_data[$];
  logic [3:0]  obs_en[$];
  logic        obs_last[$];
  logic [31:0] m_acc;
  int          m_cnt;

  rgb565_grayscale_stream #(.PIX_IN(2), .OUT_PIX(4)) dut (
    .clock(clock), .nReset(nReset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_byte_en(out_byte_en), .out_last(out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] gray_ref(input logic [15:0] p);
    int r, g, b, s;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    r = (r << 3) | (r >> 2);
    g = (g << 2) | (g >> 4);
    b = (b << 3) | (b >> 2);
    s = 54 * r + 183 * g + 19 * b;
`ifdef GRAYSCALE_ROUND_EN
    s = s + 128;
`endif
    s = s / 256;
    if (s > 255) s = 255;
    return s[7:0];
  endfunction

  task automatic sb_clear();
    stim_data.delete(); stim_last.delete();
    exp_data.delete(); exp_en.delete(); exp_last.delete();
    obs_data.delete(); obs_en.delete(); obs_last.delete();
    m_acc = '0;
    m_cnt = 0;
  endtask

  task automatic model_push(input logic [31:0] w, input logic l);
    for (int k = 0; k < 2; k++) begin
      m_acc[8*m_cnt +: 8] = gray_ref(w[16*k +: 16]);
      m_cnt++;
    end
    if (m_cnt == 4 || l) begin
      exp_data.push_back(m_acc);
      exp_en.push_back(4'((1 << m_cnt) - 1));
      exp_last.push_back(l);
      m_acc = '0;
      m_cnt = 0;
    end
  endtask

  task automatic add_word(input logic [31:0] w, input logic l);
    stim_data.push_back(w);
    stim_last.push_back(l);
  endtask

  task automatic run_stream(input int stall_at, input int stall_len, input bit rand_ready,
                            output int timeout, output int stab_err, output int drop_rel,
                            output int in_stalls);
    int          cyc;
    bit          hold;
    logic [31:0] held;
    timeout = 0; stab_err = 0; drop_rel = -1; in_stalls = 0;
    cyc = 0; hold = 0; held = '0;
    while (stim_data.size() > 0 || obs_data.size() < exp_data.size()) begin
      if (cyc >= 2000) begin
        timeout = 1;
        break;
      end
      in_valid = (stim_data.size() > 0);
      in_data  = in_valid ? stim_data[0] : 32'h0;
      in_last  = in_valid ? stim_last[0] : 1'b0;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      if (hold && (!out_valid || out_data !== held)) stab_err++;
      if (cyc >= stall_at && cyc < stall_at + stall_len && !in_ready && drop_rel < 0)
        drop_rel = cyc - stall_at;
      if (in_valid && !in_ready) in_stalls++;
      if (out_valid && out_ready) begin
        obs_data.push_back(out_data);
        obs_en.push_back(out_byte_en);
        obs_last.push_back(out_last);
      end
      hold = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) begin
        model_push(stim_data[0], stim_last[0]);
        void'(stim_data.pop_front());
        void'(stim_last.pop_front());
      end
      @(posedge clock); #1;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_valid) begin
        obs_data.push_back(out_data);
        obs_en.push_back(out_byte_en);
        obs_last.push_back(out_last);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passes++;
    checks++; if (out_byte_en !== 4'h0) $display("FAIL reset_byte_en got %h exp 0", out_byte_en); else passes++;
    checks++; if (out_data !== 32'h0) $display("FAIL reset_out_data got %h exp 0", out_data); else passes++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b exp 0", out_last); else passes++;
    nReset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b exp 1", in_ready); else passes++;
    @(posedge clock); #1;
  endtask

  task automatic test_colour();
    int to, se, dr, st;
    logic [31:0] gold;
`ifdef GRAYSCALE_ROUND_EN
    gold = 32'h13B6_0036;
`else
    gold = 32'h12B6_0035;
`endif
    sb_clear();
    add_word({16'h0000, 16'hF800}, 1'b0);
    add_word({16'h001F, 16'h07E0}, 1'b1);
    run_stream(0, 0, 0, to, se, dr, st);
    checks++; if (to != 0 || obs_data.size() != 1) $display("FAIL colour_count got %0d timeout %0d exp 1", obs_data.size(), to); else passes++;
    if (obs_data.size() > 0) begin
      checks++; if (obs_data[0] !== gold || obs_en[0] !== 4'hF) $display("FAIL colour_gold got %h/%h exp %h/f", obs_data[0], obs_en[0], gold); else passes++;
    end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      checks++;
      if (obs_data[0] !== exp_data[0] || obs_en[0] !== exp_en[0] || obs_last[0] !== exp_last[0])
        $display("FAIL colour_word got %h/%h/%b exp %h/%h/%b", obs_data[0], obs_en[0], obs_last[0], exp_data[0], exp_en[0], exp_last[0]);
      else passes++;
      void'(obs_data.pop_front()); void'(obs_en.pop_front()); void'(obs_last.pop_front());
      void'(exp_data.pop_front()); void'(exp_en.pop_front()); void'(exp_last.pop_front());
    end
  endtask

  task automatic test_white();
    int to, se, dr, st;
    sb_clear();
    add_word(32'hFFFF_FFFF, 1'b0);
    add_word(32'hFFFF_FFFF, 1'b1);
    run_stream(0, 0, 0, to, se, dr, st);
    checks++; if (to != 0 || obs_data.size() != 1) $display("FAIL white_count got %0d timeout %0d exp 1", obs_data.size(), to); else passes++;
    if (obs_data.size() > 0) begin
      checks++; if (obs_data[0] !== 32'hFFFF_FFFF || obs_en[0] !== 4'hF || obs_last[0] !== 1'b1)
        $display("FAIL white_word got %h/%h/%b exp ffffffff/f/1", obs_data[0], obs_en[0], obs_last[0]);
      else passes++;
    end
  endtask

  task automatic test_partial_flush();
    int to, se, dr, st;
    sb_clear();
    add_word(32'hFFFF_FFFF, 1'b1);
    run_stream(0, 0, 0, to, se, dr, st);
    checks++; if (to != 0 || obs_data.size() != 1) $display("FAIL partial_count got %0d timeout %0d exp 1", obs_data.size(), to); else passes++;
    if (obs_data.size() > 0) begin
      checks++; if (obs_data[0][15:0] !== 16'hFFFF || obs_en[0] !== 4'b0011 || obs_last[0] !== 1'b1)
        $display("FAIL partial_word got %h/%b/%b exp ffff/0011/1", obs_data[0][15:0], obs_en[0], obs_last[0]);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int to, se, dr, st;
    sb_clear();
    for (int i = 0; i < 8; i++) add_word($urandom, (i == 7));
    run_stream(0, 0, 0, to, se, dr, st);
    checks++; if (to != 0 || st != 0) $display("FAIL b2b_in_stalls got %0d timeout %0d exp 0", st, to); else passes++;
    checks++; if (obs_data.size() != exp_data.size()) $display("FAIL b2b_count got %0d exp %0d", obs_data.size(), exp_data.size()); else passes++;
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      checks++;
      if (obs_data[0] !== exp_data[0] || obs_en[0] !== exp_en[0] || obs_last[0] !== exp_last[0])
        $display("FAIL b2b_word got %h/%h/%b exp %h/%h/%b", obs_data[0], obs_en[0], obs_last[0], exp_data[0], exp_en[0], exp_last[0]);
      else passes++;
      void'(obs_data.pop_front()); void'(obs_en.pop_front()); void'(obs_last.pop_front());
      void'(exp_data.pop_front()); void'(exp_en.pop_front()); void'(exp_last.pop_front());
    end
  endtask

  task automatic test_back_pressure();
    int to, se, dr, st;
    sb_clear();
    for (int i = 0; i < 8; i++) add_word($urandom, (i == 7));
    run_stream(3, 10, 0, to, se, dr, st);
    checks++; if (to != 0) $display("FAIL bp_timeout got %0d exp 0", to); else passes++;
    checks++; if (se != 0) $display("FAIL bp_stable got %0d changes exp 0", se); else passes++;
    checks++; if (dr < 0 || dr > 3) $display("FAIL bp_ready_drop got %0d cycles exp 0..3", dr); else passes++;
    checks++; if (obs_data.size() != exp_data.size()) $display("FAIL bp_count got %0d exp %0d", obs_data.size(), exp_data.size()); else passes++;
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      checks++;
      if (obs_data[0] !== exp_data[0] || obs_en[0] !== exp_en[0] || obs_last[0] !== exp_last[0])
        $display("FAIL bp_word got %h/%h/%b exp %h/%h/%b", obs_data[0], obs_en[0], obs_last[0], exp_data[0], exp_en[0], exp_last[0]);
      else passes++;
      void'(obs_data.pop_front()); void'(obs_en.pop_front()); void'(obs_last.pop_front());
      void'(exp_data.pop_front()); void'(exp_en.pop_front()); void'(exp_last.pop_front());
    end
  endtask

  task automatic test_random();
    int to, se, dr, st;
    sb_clear();
    for (int i = 0; i < 12; i++) add_word($urandom, (i == 4) || (i == 11));
    run_stream(0, 0, 1, to, se, dr, st);
    checks++; if (to != 0 || se != 0) $display("FAIL rand_flow got timeout %0d unstable %0d exp 0/0", to, se); else passes++;
    checks++; if (obs_data.size() != exp_data.size()) $display("FAIL rand_count got %0d exp %0d", obs_data.size(), exp_data.size()); else passes++;
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      checks++;
      if (obs_data[0] !== exp_data[0] || obs_en[0] !== exp_en[0] || obs_last[0] !== exp_last[0])
        $display("FAIL rand_word got %h/%h/%b exp %h/%h/%b", obs_data[0], obs_en[0], obs_last[0], exp_data[0], exp_en[0], exp_last[0]);
      else passes++;
      void'(obs_data.pop_front()); void'(obs_en.pop_front()); void'(obs_last.pop_front());
      void'(exp_data.pop_front()); void'(exp_en.pop_front()); void'(exp_last.pop_front());
    end
  endtask

  task automatic test_mid_reset();
    int to, se, dr, st;
    sb_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_last = 1'b0;
      @(posedge clock); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (out_valid !== 1'b1) $display("FAIL midrst_pre_valid got %b exp 1", out_valid); else passes++;
    nReset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_byte_en !== 4'h0) $display("FAIL midrst_async got %b/%h exp 0/0", out_valid, out_byte_en); else passes++;
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL midrst_edge got %b/%b exp 0/0", out_valid, in_ready); else passes++;
    nReset = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) add_word($urandom, (i == 3));
    run_stream(0, 0, 0, to, se, dr, st);
    checks++; if (to != 0 || obs_data.size() != exp_data.size()) $display("FAIL midrst_count got %0d exp %0d", obs_data.size(), exp_data.size()); else passes++;
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      checks++;
      if (obs_data[0] !== exp_data[0] || obs_en[0] !== exp_en[0] || obs_last[0] !== exp_last[0])
        $display("FAIL midrst_word got %h/%h/%b exp %h/%h/%b", obs_data[0], obs_en[0], obs_last[0], exp_data[0], exp_en[0], exp_last[0]);
      else passes++;
      void'(obs_data.pop_front()); void'(obs_en.pop_front()); void'(obs_last.pop_front());
      void'(exp_data.pop_front()); void'(exp_en.pop_front()); void'(exp_last.pop_front());
    end
  endtask

  initial begin
    nReset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    test_reset();
    test_colour();
    test_white();
    test_partial_flush();
    test_back_to_back();
    test_back_pressure();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
